// File: rtl/stim_gray_sequencer_if.sv
// -----------------------------------------------------------------------------
// stim_gray_sequencer_if
// Control and stimulus bundle between the Gray-walk stimulus sequencer and
// its consumers (the open-collector logic stage under test and a comparator).
//   master : the sequencer; samples start/pause, drives stimulus and status
//   slave  : the consumer side; drives start/pause, observes the rest
// -----------------------------------------------------------------------------
interface stim_gray_sequencer_if;

   logic       start;        // level; begins a sequence from IDLE or DONE
   logic       pause;        // level; freezes the walk while high in RUN
   logic       a;            // stimulus bit a
   logic       b;            // stimulus bit b
   logic       c;            // stimulus bit c
   logic [2:0] step_idx;     // index of the vector currently driven
   logic       step_strobe;  // first cycle of a newly driven vector
   logic       busy;         // sequence in progress (running or held)
   logic       done;         // single pass finished

   modport master (
      input  start,
      input  pause,
      output a,
      output b,
      output c,
      output step_idx,
      output step_strobe,
      output busy,
      output done
   );

   modport slave (
      output start,
      output pause,
      input  a,
      input  b,
      input  c,
      input  step_idx,
      input  step_strobe,
      input  busy,
      input  done
   );

endinterface : stim_gray_sequencer_if

// File: rtl/stim_gray_sequencer.sv
// -----------------------------------------------------------------------------
// stim_gray_sequencer
// Stimulus source for the 3-input open-collector logic stage. Walks {a,b,c}
// through an 8-step single-bit-change sequence
//    000 -> 100 -> 110 -> 111 -> 101 -> 001 -> 011 -> 010
// holding every vector for DWELL unpaused clocks, and reports step index,
// a new-vector strobe, busy and done for a downstream comparator.
//
// Parameters
//   DWELL : clocks each vector is held, 1..65535
//   CNT_W : dwell counter width, 2**CNT_W must exceed DWELL
//
// Build option
//   STIM_SEQ_LOOP_EN : when defined the walk wraps from step 7 back to step 0
//                      and keeps running; dropping start at a step boundary
//                      returns to IDLE. DONE is never reached in that build.
//                      When undefined the sequencer makes a single pass and
//                      stops in DONE holding the last vector.
//
// Every output comes straight from a flop; inputs only reach the outputs
// through the next-state logic.
// -----------------------------------------------------------------------------
module stim_gray_sequencer #(
   parameter int unsigned DWELL = 100,
   parameter int unsigned CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   stim_gray_sequencer_if.master bus
);

   // --------------------------------------------------------------------------
   // Types and constants
   // --------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // waiting for start, outputs 000
      ST_RUN  = 2'd1,   // counting dwell on the current vector
      ST_HOLD = 2'd2,   // paused; counter and outputs frozen
      ST_DONE = 2'd3    // single pass complete, last vector held
   } state_t;

   // Counter value on the final cycle of a vector's dwell.
   localparam logic [CNT_W-1:0] LP_CNT_LAST  = CNT_W'(DWELL - 1);
   localparam logic [2:0]       LP_STEP_FIRST = 3'd0;
   localparam logic [2:0]       LP_STEP_LAST  = 3'd7;

   // Vector table, {a,b,c} for each step. Neighbouring entries differ in
   // exactly one bit, so the stage under test sees one input edge per step.
   function automatic logic [2:0] f_vector(input logic [2:0] i_step);
      logic [2:0] v;
      unique case (i_step)
         3'd0:    v = 3'b000;
         3'd1:    v = 3'b100;
         3'd2:    v = 3'b110;
         3'd3:    v = 3'b111;
         3'd4:    v = 3'b101;
         3'd5:    v = 3'b001;
         3'd6:    v = 3'b011;
         3'd7:    v = 3'b010;
         default: v = 3'b000;
      endcase
      return v;
   endfunction

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   state_t           r_state;
   logic [2:0]       r_step;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_vec;
   logic             r_strobe;
   logic             r_busy;
   logic             r_done;

   // --------------------------------------------------------------------------
   // Next-state values
   // --------------------------------------------------------------------------
   state_t           w_state_nxt;
   logic [2:0]       w_step_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_strobe_nxt;
   logic [2:0]       w_vec_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic             w_dwell_end;

   // Final cycle of the current vector's dwell.
   assign w_dwell_end = (r_cnt == LP_CNT_LAST);

   // Next-state decode: start handling, pause/hold, dwell expiry and step advance.
   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // leaves one unassigned; an unassigned path would infer a latch.
      w_state_nxt  = r_state;
      w_step_nxt   = r_step;
      w_cnt_nxt    = r_cnt;
      w_strobe_nxt = 1'b0;

      unique case (r_state)
         // Idle and done behave the same towards start: load step 0, clear
         // the counter and strobe. pause has no effect here.
         ST_IDLE,
         ST_DONE: begin
            if (bus.start) begin
               w_state_nxt  = ST_RUN;
               w_step_nxt   = LP_STEP_FIRST;
               w_cnt_nxt    = '0;
               w_strobe_nxt = 1'b1;
            end
         end

         // Running and held share one rule: a cycle with pause high freezes
         // everything; a cycle with pause low counts. That makes the first
         // unpaused cycle out of HOLD a counting cycle, so a vector always
         // sees exactly DWELL unpaused cycles, and a pause landing on the
         // expiry cycle defers the advance to the first cycle after resume.
         ST_RUN,
         ST_HOLD: begin
            if (bus.pause) begin
               w_state_nxt = ST_HOLD;
            end else if (!w_dwell_end) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = r_cnt + 1'b1;
            end else begin
               w_cnt_nxt = '0;
`ifdef STIM_SEQ_LOOP_EN
               if (!bus.start) begin
                  // start dropped at a boundary: return to idle, outputs 000
                  w_state_nxt = ST_IDLE;
                  w_step_nxt  = LP_STEP_FIRST;
               end else begin
                  // step 7 wraps to step 0 through the natural 3-bit overflow
                  w_state_nxt  = ST_RUN;
                  w_step_nxt   = r_step + 3'd1;
                  w_strobe_nxt = 1'b1;
               end
`else
               if (r_step == LP_STEP_LAST) begin
                  // last vector stays on the outputs in DONE
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt  = ST_RUN;
                  w_step_nxt   = r_step + 3'd1;
                  w_strobe_nxt = 1'b1;
               end
`endif
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_step_nxt  = LP_STEP_FIRST;
            w_cnt_nxt   = '0;
         end
      endcase

      // Output flops are loaded from the next-state view so that vector,
      // index, strobe and status all change on the same edge.
      w_vec_nxt  = f_vector(w_step_nxt);
      w_busy_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_HOLD);
      w_done_nxt = (w_state_nxt == ST_DONE);
   end

   // State, counter and registered outputs; reset aborts any step at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_step   <= LP_STEP_FIRST;
         r_cnt    <= '0;
         r_vec    <= 3'b000;
         r_strobe <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // of the same cycle regardless of statement order.
         r_state  <= w_state_nxt;
         r_step   <= w_step_nxt;
         r_cnt    <= w_cnt_nxt;
         r_vec    <= w_vec_nxt;
         r_strobe <= w_strobe_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs, straight from flops
   // --------------------------------------------------------------------------
   assign bus.a           = r_vec[2];
   assign bus.b           = r_vec[1];
   assign bus.c           = r_vec[0];
   assign bus.step_idx    = r_step;
   assign bus.step_strobe = r_strobe;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;

endmodule : stim_gray_sequencer

// File: doc/stim_gray_sequencer.md
Name: stim_gray_sequencer

Overview:
- Synthesizable stimulus source that sits directly upstream of the 3-input open-collector logic stage (switch/gate/assign variants).
- Drives a, b, c through a fixed 8-step single-bit-change walk, holding each vector for a programmable number of clocks.
- Lets the three implementations be exercised on silicon/FPGA without a behavioural bench.
- Provides step index, step strobe and done status for a downstream comparator.

Parameters:
DWELL, 100, clock cycles each vector is held; legal range 1..65535
CNT_W, 16, dwell counter width; must satisfy 2^CNT_W > DWELL

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level; sampled each clk; begins a sequence from IDLE or DONE
pause  input  1  level; freezes dwell counter and outputs while high in RUN
a  output  1  stimulus bit a (registered)
b  output  1  stimulus bit b (registered)
c  output  1  stimulus bit c (registered)
step_idx  output  3  index of vector currently driven, 0..7
step_strobe  output  1  one-cycle pulse in first cycle a new vector is driven
busy  output  1  high in RUN and HOLD
done  output  1  high in DONE

Behaviour:
- Reset: one clock and one reset. Reset is asynchronous and active-low on rst_n, with the clock and reset ports named clk and rst_n. While rst_n=0:
  - state=IDLE
  - a=b=c=0, step_idx=0
  - step_strobe=0, busy=0, done=0
  - dwell counter=0
  Reset asserted mid-sequence aborts immediately with the same values; no partial step completes.
- Vector table, step 0..7, as {a,b,c}: 000, 100, 110, 111, 101, 001, 011, 010. Exactly one bit changes between consecutive steps.
- States:
  - IDLE: outputs 000. start=1 → RUN at next edge. That edge loads step 0 (000), clears the counter and pulses step_strobe.
  - RUN: counter increments each clk. pause=1 → HOLD, counter and outputs frozen. When the counter reaches DWELL-1 and pause=0, one of two things happens at that edge:
    - step_idx<7: step_idx increments, the new vector is driven, counter clears, step_strobe=1 for one cycle.
    - step_idx=7: → DONE.
  - HOLD: everything frozen. pause=0 → RUN at next edge; counting resumes from the frozen value. No strobe on resume.
  - DONE: done=1, busy=0, last vector (010) held. start=1 → same restart as from IDLE; done falls on that edge.
- Timing:
  - Each vector is driven for exactly DWELL unpaused cycles.
  - Total run is 8*DWELL cycles plus paused cycles.
  - step_strobe and vector change occur on the same edge.
- Simultaneous events:
  - start is ignored in RUN and HOLD.
  - pause is ignored in IDLE and DONE.
  - If pause=1 on the cycle the dwell expires, pause wins: step does not advance, and it advances on the first unpaused cycle after resume.
- DWELL=1: a new vector every cycle, so step_strobe stays high for 8 consecutive cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: STIM_SEQ_LOOP_EN.
- Defined: after step 7's dwell expires, the FSM wraps to step 0 (vector 000, strobe pulses) and stays in RUN indefinitely. DONE is unreachable and done stays 0. The only exits are reset or deassertion handling below.
  - start deasserted at a step boundary → IDLE, with outputs returned to 000 and busy=0.
- Undefined: single pass ending in DONE as above. start level is irrelevant during RUN.

Test Plan:
1. DWELL=4, reset released, start pulsed 1 cycle → a,b,c step 000,100,110,111,101,001,011,010, each held 4 cycles. step_strobe pulses at cycles 0,4,...,28 after start edge. done=1 at cycle 32, outputs hold 010.
2. DWELL=4, pause high for 3 cycles starting at cycle 2 of step 2 → step 2 (110) held 7 cycles, no extra strobe, total run 35 cycles.
3. DWELL=4, rst_n low asynchronously at step 5 mid-dwell → outputs 000, step_idx=0, busy=0 immediately without clk. Restart with start gives full sequence from step 0.
4. DWELL=1 → 8 consecutive strobes, vector changes every clock, done after 8 cycles. start held high during run has no effect. start high in DONE restarts from 000.
5. Pause and expiry coincide at step 3 last cycle → step stays 111 until pause low, then advances to 101 one cycle later.
6. With STIM_SEQ_LOOP_EN, DWELL=2, start held high → after 010 the vector returns to 000 with strobe and cycles indefinitely. Dropping start at a boundary → IDLE, outputs 000.
